// File: rtl/bram_burst_reader.sv
// Streams a burst of words out of a single-port block RAM through a 2-entry FIFO with valid/ready handshake.
// Define BRAM_READER_WRAP_EN to let bursts wrap from memDepth-1 back to address 0.
module bram_burst_reader #(
  parameter int blockLength     = 32,
  parameter int memDepth        = 64,
  parameter int addressBitWidth = 6
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  logic                       start,
  input  logic [addressBitWidth-1:0] startAddress,
  input  logic [addressBitWidth:0]   burstLength,
  output logic [addressBitWidth-1:0] memAddress,
  output logic                       memWriteEnable,
  input  logic [blockLength-1:0]     memDataIn,
  output logic [blockLength-1:0]     dataOut,
  output logic                       dataValid,
  input  logic                       dataReady,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [addressBitWidth+1:0] DEPTH_EXT = (addressBitWidth+2)'(memDepth);
  localparam logic [addressBitWidth:0]   ONE_LEFT  = (addressBitWidth+1)'(1);

  state_t                     state, state_next;
  logic [addressBitWidth-1:0] addr, addr_next;
  logic [addressBitWidth:0]   remaining;
  logic                       in_flight;
  logic [blockLength-1:0]     fifo_mem [2];
  logic                       rd_ptr, wr_ptr;
  logic [1:0]                 count;
  logic [2:0]                 occupancy;
  logic                       issue, pop, accept_burst, done_next, error_next, range_bad;

`ifdef BRAM_READER_WRAP_EN
  localparam logic [addressBitWidth-1:0] LAST_ADDR = addressBitWidth'(memDepth - 1);
  assign range_bad = {1'b0, burstLength} > DEPTH_EXT;
  assign addr_next = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
`else
  logic [addressBitWidth+1:0] end_addr;
  assign end_addr  = {2'b00, startAddress} + {1'b0, burstLength};
  assign range_bad = end_addr > DEPTH_EXT;
  assign addr_next = addr + 1'b1;
`endif

  assign dataValid      = (count != 2'd0);
  assign dataOut        = fifo_mem[rd_ptr];
  assign pop            = dataValid & dataReady;
  assign memAddress     = addr;
  assign memWriteEnable = 1'b0;
  assign busy           = (state != IDLE);

  // A word leaving on this edge frees its slot, which keeps 1 word/cycle with dataReady held high.
  assign occupancy = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
  assign issue     = (state == READ) && (remaining != '0) && (occupancy < 3'd2);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept_burst = 1'b0;
    done_next    = 1'b0;
    error_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (range_bad) begin
            error_next = 1'b1;
          end else if (burstLength == '0) begin
            done_next = 1'b1;
          end else begin
            accept_burst = 1'b1;
            state_next   = READ;
          end
        end
      end
      READ: begin
        if (issue && (remaining == ONE_LEFT)) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && (count == 2'd1) && !in_flight) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      addr      <= '0;
      remaining <= '0;
      in_flight <= 1'b0;
      count     <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      done      <= done_next;
      error     <= error_next;
      in_flight <= issue;
      if (accept_burst) begin
        addr      <= startAddress;
        remaining <= burstLength;
      end else if (issue) begin
        addr      <= addr_next;
        remaining <= remaining - 1'b1;
      end
      if (in_flight) begin
        fifo_mem[wr_ptr] <= memDataIn;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, in_flight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: synchronous-read RAM model, directed bursts plus random bursts
// checked against an address-order word list computed from the RAM contents.
module tb_bram_burst_reader;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clock, resetN, start, memWriteEnable, dataValid, dataReady, busy, done, error;
  logic [AW-1:0] startAddress, memAddress;
  logic [AW:0]   burstLength;
  logic [DW-1:0] memDataIn, dataOut;
  logic [DW-1:0] ram [DEPTH];

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  bram_burst_reader #(.blockLength(DW), .memDepth(DEPTH), .addressBitWidth(AW)) dut (
    .clock(clock), .resetN(resetN), .start(start), .startAddress(startAddress),
    .burstLength(burstLength), .memAddress(memAddress), .memWriteEnable(memWriteEnable),
    .memDataIn(memDataIn), .dataOut(dataOut), .dataValid(dataValid), .dataReady(dataReady),
    .busy(busy), .done(done), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) memDataIn <= ram[memAddress];

  initial begin
    #1000000;
    $display("FAIL watchdog: observed time limit reached, required $finish before it");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pick_ready(input int mode, input int unsigned cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // mode 0: ready held high, 1: ready 1,0,0,1 repeating, 2: random ready
  task automatic run_burst(input int unsigned sa, input int unsigned len, input int mode,
                           input bit restart_mid, input string tag);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] prev_d;
    logic [63:0]   obs;
    bit            prev_stall, ready;
    int unsigned   done_cyc, last_xfer, first_v, busy_bad, err_seen, budget;
    for (int unsigned k = 0; k < len; k++) exp_q.push_back(ram[(sa + k) % DEPTH]);
    prev_stall = 1'b0; prev_d = '0;
    done_cyc = 0; last_xfer = 0; first_v = 0; busy_bad = 0; err_seen = 0;
    budget = len * 8 + 20;
    @(negedge clock);
    start = 1'b1; startAddress = AW'(sa); burstLength = (AW+1)'(len); dataReady = 1'b1;
    for (int unsigned cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clock);
      start = restart_mid && (cyc == 4 || cyc == 5);
      if (start) begin
        startAddress = AW'(sa + 7);
        burstLength  = (AW+1)'(1);
      end
      ready = pick_ready(mode, cyc);
      dataReady = ready;
      if (prev_stall)
        check({tag, "_hold"}, {31'b0, dataValid, dataOut}, {31'b0, 1'b1, prev_d});
      if (error) err_seen++;
      if (dataValid && first_v == 0) first_v = cyc;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (dataValid && ready) begin
        got_q.push_back(dataOut);
        last_xfer = cyc;
      end
      prev_stall = dataValid && !ready;
      prev_d     = dataOut;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {63'b0, done_cyc != 0}, 64'd1);
    check({tag, "_done_timing"}, 64'(done_cyc), 64'(last_xfer + 1));
    check({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
    check({tag, "_busy_during"}, 64'(busy_bad), 64'd0);
    check({tag, "_no_error"}, 64'(err_seen), 64'd0);
    check({tag, "_count"}, 64'(got_q.size()), 64'(len));
    for (int unsigned k = 0; k < len; k++) begin
      obs = (k < got_q.size()) ? {32'b0, got_q[k]} : 'x;
      check({tag, "_word"}, obs, {32'b0, exp_q[k]});
    end
    if (mode == 0) begin
      check({tag, "_first_valid"}, 64'(first_v), 64'd3);
      check({tag, "_last_xfer"}, 64'(last_xfer), 64'(len + 2));
    end
    @(negedge clock);
    check({tag, "_done_pulse"}, {62'b0, done, dataValid}, 64'd0);
  endtask

  task automatic check_reject(input int unsigned sa, input int unsigned len, input string tag);
    int unsigned bad;
    bad = 0;
    @(negedge clock);
    start = 1'b1; startAddress = AW'(sa); burstLength = (AW+1)'(len); dataReady = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_error"}, {63'b0, error}, 64'd1);
    check({tag, "_busy"}, {62'b0, busy, dataValid}, 64'd0);
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clock);
      if (error || busy || dataValid || done) bad++;
    end
    check({tag, "_quiet"}, 64'(bad), 64'd0);
  endtask

  task automatic check_zero(input int unsigned sa, input string tag);
    int unsigned bad;
    bad = 0;
    @(negedge clock);
    start = 1'b1; startAddress = AW'(sa); burstLength = '0; dataReady = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_done"}, {63'b0, done}, 64'd1);
    check({tag, "_busy_valid_err"}, {61'b0, busy, dataValid, error}, 64'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clock);
      if (done || busy || dataValid || error) bad++;
    end
    check({tag, "_quiet"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int unsigned sa, len, xfers;
    for (int unsigned i = 0; i < DEPTH; i++) ram[i] = DW'(i);
    resetN = 1'b0; start = 1'b0; startAddress = '0; burstLength = '0; dataReady = 1'b0;
    #1;
    check("reset_addr", 64'(memAddress), 64'd0);
    check("reset_data", 64'(dataOut), 64'd0);
    check("reset_flags", {59'b0, memWriteEnable, dataValid, busy, done, error}, 64'd0);
    repeat (3) @(negedge clock);
    resetN = 1'b1;

    run_burst(4, 8, 0, 1'b0, "basic");
    run_burst(4, 8, 1, 1'b0, "stall_pattern");
`ifdef BRAM_READER_WRAP_EN
    run_burst(60, 8, 0, 1'b0, "wrap");
`else
    check_reject(60, 8, "overrun");
`endif
    check_zero(17, "zero_len");
    run_burst(0, 64, 0, 1'b0, "full_depth");
    run_burst(20, 8, 0, 1'b1, "restart_ignored");
    run_burst(33, 1, 1, 1'b0, "single_word");

    // Reset after the third word of a 10-word burst, then a fresh 2-word burst.
    @(negedge clock);
    start = 1'b1; startAddress = AW'(10); burstLength = (AW+1)'(10); dataReady = 1'b1;
    xfers = 0;
    for (int unsigned cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (dataValid && dataReady) xfers++;
      if (xfers == 3) break;
    end
    check("rst_third_word", 64'(xfers), 64'd3);
    @(negedge clock);
    resetN = 1'b0;
    #1;
    check("rst_mid_addr", 64'(memAddress), 64'd0);
    check("rst_mid_flags", {60'b0, dataValid, busy, done, error}, 64'd0);
    check("rst_mid_data", 64'(dataOut), 64'd0);
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    run_burst(0, 2, 0, 1'b0, "after_reset");

    for (int unsigned i = 0; i < DEPTH; i++) ram[i] = $urandom;
    for (int unsigned n = 0; n < 20; n++) begin
      sa = $urandom_range(0, DEPTH - 1);
`ifdef BRAM_READER_WRAP_EN
      len = $urandom_range(1, DEPTH);
`else
      len = $urandom_range(1, DEPTH - sa);
`endif
      run_burst(sa, len, (n % 3 == 0) ? 1 : 2, 1'b0, "random");
    end
`ifndef BRAM_READER_WRAP_EN
    for (int unsigned n = 0; n < 3; n++) begin
      sa  = $urandom_range(1, DEPTH - 1);
      len = $urandom_range(DEPTH - sa + 1, DEPTH);
      check_reject(sa, len, "random_overrun");
    end
`endif
    check("write_enable", {63'b0, memWriteEnable}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
